ttl245_bus_sequencer: RTL

//  Upstream controller for an octal 74LS245 bus transceiver.
//  - Accepts single-byte read/write requests and generates the transceiver's DIR and OE_n.
//  - Drives the A-side bus during writes (A->B) and captures the A-side bus during reads (B->A).
//  - Enforces a bus-turnaround dead time whenever the direction changes.
//  - Holds OE_n low long enough to cover the transceiver's propagation delay.

---
 rtl/ttl245_bus_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ttl245_bus_sequencer.sv
// ttl245_bus_sequencer
//  Upstream controller for an octal 74LS245 bus transceiver. Accepts single-byte read/write
//  requests, sequences the transceiver's DIR and OE_n with a turnaround dead time on every
//  direction change, drives the A-side bus during writes and captures it during reads.
//
// Ports
//  clk      in   1  single clock, rising edge
//  reset    in   1  synchronous, active-high reset
//  req      in   1  transfer request, sampled only while idle
//  wr       in   1  1 = write (A->B), 0 = read (B->A); sampled with req
//  wdata    in   8  write data; sampled with req
//  busy     out  1  transfer in progress
//  ack      out  1  one-cycle completion pulse
//  rd_data  out  8  captured read data, held until the next read completes
//  DIR      out  1  transceiver direction, 1 = A to B
//  OE_n     out  1  transceiver output enable, active low
//  a_out    out  8  value driven onto the A-side bus
//  a_oe     out  1  A-side tri-state enable for a_out
//  a_in     in   8  A-side bus as seen by this block

module ttl245_bus_sequencer #(
  parameter int unsigned SETTLE_CYCLES     = 4,
  parameter int unsigned TURNAROUND_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rd_data,
  output logic       DIR,
  output logic       OE_n,
  output logic [7:0] a_out,
  output logic       a_oe,
  input  logic [7:0] a_in
);

  localparam int unsigned MaxCycles = (SETTLE_CYCLES > TURNAROUND_CYCLES) ?
                                      SETTLE_CYCLES : TURNAROUND_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  // Counters load N-1 on state entry and the state exits when they reach zero.
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TurnLoad   = CntW'(TURNAROUND_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StSettle,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            wr_q, wr_d;
  logic [7:0]      a_out_q, a_out_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            oe_n_q, oe_n_d;
  logic            a_oe_q, a_oe_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            xfer_on;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    wr_d      = wr_q;
    a_out_d   = a_out_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          wr_d    = wr;
          a_out_d = wdata;
          // DIR only ever moves here, while OE_n is still high.
          if (wr != dir_q) begin
            dir_d   = wr;
            state_d = StTurn;
            cnt_d   = TurnLoad;
          end else begin
            state_d = StSettle;
            cnt_d   = SettleLoad;
          end
        end
      end
      StTurn: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cnt_d   = '0;
          if (!wr_q) begin
            rd_data_d = a_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the pins are glitch-free
    // while still changing in the same cycle as the state.
    xfer_on = (state_d == StSettle) || (state_d == StDone);
    oe_n_d  = !xfer_on;
    a_oe_d  = xfer_on && dir_d;
    ack_d   = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      wr_q      <= 1'b0;
      a_out_q   <= 8'h00;
      rd_data_q <= 8'h00;
      oe_n_q    <= 1'b1;
      a_oe_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      wr_q      <= wr_d;
      a_out_q   <= a_out_d;
      rd_data_q <= rd_data_d;
      oe_n_q    <= oe_n_d;
      a_oe_q    <= a_oe_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rd_data = rd_data_q;
  assign DIR     = dir_q;
  assign OE_n    = oe_n_q;
  assign a_out   = a_out_q;
  assign a_oe    = a_oe_q;

endmodule
